// File: rtl/pid_sched_pkg.sv
// Shared types and defaults for the PID loop scheduler and its round-robin arbiter.
package pid_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after ptr, wrapping,
// with ptr itself as the lowest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);

  logic [CH_W-1:0] idx;

  // Walk from farthest to nearest so the channel closest after ptr is the last write.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pid_loop_scheduler.sv
// Shares one PID engine across NUM_CH channels: prescaled sample tick, pending
// tracking, round-robin issue over req/ack with timeout, sticky overrun/timeout status.
module pid_loop_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       clk_prescaler,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sticky_clr,
  input  logic              eng_ack,
  output logic              eng_req,
  output logic [CH_W-1:0]   eng_ch,
  output logic              tick,
  output logic              busy,
  output logic [NUM_CH-1:0] pending,
  output logic              round_done,
  output logic [NUM_CH-1:0] overrun_sticky,
  output logic [NUM_CH-1:0] timeout_sticky
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

  sched_state_t      state, state_next;
  logic [15:0]       cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [CH_W-1:0]   ptr, ptr_next, eng_ch_next, grant;
  logic              grant_vld;
  logic              expired, done;
  logic [NUM_CH-1:0] clr, pending_next, ovr_set, tmo_set;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_vld)
  );

  always_comb begin
    expired = (state == ISSUE) && !eng_ack && (wcnt == WCNT_MAX);
    done    = (state == ISSUE) && (eng_ack || wcnt == WCNT_MAX);
    clr     = '0;
    tmo_set = '0;
    if (done)    clr[eng_ch]     = 1'b1;
    if (expired) tmo_set[eng_ch] = 1'b1;
    // A tick re-arms every enabled channel even if it is being cleared this cycle.
    pending_next = (pending & ~clr & ch_enable) | (tick ? ch_enable : '0);
    ovr_set      = tick ? (pending & ch_enable & ~clr) : '0;
  end

  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    eng_ch_next = eng_ch;
    case (state)
      IDLE, GAP: begin
        if (grant_vld) begin
          state_next  = ISSUE;
          eng_ch_next = grant;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (done) begin
          state_next = GAP;
          ptr_next   = eng_ch;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= clk_prescaler) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 16'd1;
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= CH_W'(NUM_CH - 1);
      eng_ch         <= '0;
      eng_req        <= 1'b0;
      busy           <= 1'b0;
      round_done     <= 1'b0;
      wcnt           <= '0;
      pending        <= '0;
      overrun_sticky <= '0;
      timeout_sticky <= '0;
    end else begin
      state          <= state_next;
      ptr            <= ptr_next;
      eng_ch         <= eng_ch_next;
      eng_req        <= (state_next == ISSUE);
      busy           <= (state_next != IDLE);
      round_done     <= (state_next == GAP) && (pending_next == '0);
      wcnt           <= (state == ISSUE && state_next == ISSUE) ? wcnt + 1'b1 : '0;
      pending        <= pending_next;
      overrun_sticky <= (sticky_clr ? '0 : overrun_sticky) | ovr_set;
      timeout_sticky <= (sticky_clr ? '0 : timeout_sticky) | tmo_set;
    end
  end

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Directed self-checking bench for pid_loop_scheduler (NUM_CH=4, TIMEOUT=64).
module tb_pid_loop_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] clk_prescaler;
  logic [3:0]  ch_enable;
  logic        sticky_clr;
  logic        eng_ack;
  logic        eng_req;
  logic [1:0]  eng_ch;
  logic        tick;
  logic        busy;
  logic [3:0]  pending;
  logic        round_done;
  logic [3:0]  overrun_sticky;
  logic [3:0]  timeout_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  pid_loop_scheduler #(.NUM_CH(4), .CH_W(2), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_prescaler  (clk_prescaler),
    .ch_enable      (ch_enable),
    .sticky_clr     (sticky_clr),
    .eng_ack        (eng_ack),
    .eng_req        (eng_req),
    .eng_ch         (eng_ch),
    .tick           (tick),
    .busy           (busy),
    .pending        (pending),
    .round_done     (round_done),
    .overrun_sticky (overrun_sticky),
    .timeout_sticky (timeout_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return tick;
      1:       return eng_req;
      default: return round_done;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int max_cycles);
    int n = 0;
    while (sel(which) !== 1'b1 && n < max_cycles) begin
      step(1);
      n++;
    end
    check(tag, 32'(sel(which)), 1);
  endtask

  task automatic ack_after(input int d);
    step(d);
    eng_ack = 1'b1;
    step(1);
    eng_ack = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] psc, input logic [3:0] en);
    rst_n         = 1'b0;
    eng_ack       = 1'b0;
    sticky_clr    = 1'b0;
    clk_prescaler = psc;
    ch_enable     = en;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int r_prev;
    int n;

    // Reset values and prescaler period
    do_reset(16'd9, 4'b0001);
    check("rst eng_req", 32'(eng_req), 0);
    check("rst eng_ch", 32'(eng_ch), 0);
    check("rst tick", 32'(tick), 0);
    check("rst busy", 32'(busy), 0);
    check("rst pending", 32'(pending), 0);
    check("rst round_done", 32'(round_done), 0);
    check("rst overrun", 32'(overrun_sticky), 0);
    check("rst timeout", 32'(timeout_sticky), 0);
    wait_for("psc tick", 0, 20);
    t0 = cyc;
    step(1);
    check("psc pending T+1", 32'(pending), 32'h1);
    check("psc req T+1", 32'(eng_req), 0);
    step(1);
    check("psc req T+2", 32'(eng_req), 1);
    check("psc eng_ch", 32'(eng_ch), 0);
    check("psc busy", 32'(busy), 1);
    ack_after(1);
    check("psc gap req", 32'(eng_req), 0);
    check("psc round_done", 32'(round_done), 1);
    wait_for("psc tick2", 0, 20);
    check("psc period", 32'(cyc - t0), 10);

    // Round-robin order and spacing
    do_reset(16'd3, 4'b1111);
    wait_for("rr tick", 0, 10);
    clk_prescaler = 16'hFFFF;
    step(1);
    check("rr pending", 32'(pending), 32'hF);
    r_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_for("rr req", 1, 10);
      if (i > 0) check("rr spacing", 32'(cyc - r_prev), 3);
      r_prev = cyc;
      check("rr order", 32'(eng_ch), 32'(i));
      ack_after(1);
      check("rr round_done", 32'(round_done), 32'(i == 3));
    end
    check("rr overrun", 32'(overrun_sticky), 0);

    // Overrun, sticky clear, set beats clear
    do_reset(16'd5, 4'b1111);
    wait_for("ovr tick", 0, 10);
    t0 = cyc;
    wait_for("ovr req", 1, 10);
    check("ovr req latency", 32'(cyc - t0), 2);
    check("ovr eng_ch", 32'(eng_ch), 0);
    ack_after(4);
    check("ovr sticky", 32'(overrun_sticky), 32'hE);
    check("ovr pending set wins", 32'(pending), 32'hF);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("ovr cleared", 32'(overrun_sticky), 0);
    check("ovr next ch", 32'(eng_ch), 1);
    wait_for("ovr tick2", 0, 10);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("ovr set+clr", 32'(overrun_sticky), 32'hF);
    check("ovr no timeout", 32'(timeout_sticky), 0);

    // Engine timeout
    do_reset(16'd3, 4'b1100);
    wait_for("tmo tick", 0, 10);
    clk_prescaler = 16'hFFFF;
    wait_for("tmo req", 1, 10);
    check("tmo eng_ch", 32'(eng_ch), 2);
    n = 0;
    while (eng_req === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    check("tmo req width", 32'(n), 64);
    check("tmo sticky", 32'(timeout_sticky), 32'h4);
    check("tmo no round_done", 32'(round_done), 0);
    step(1);
    check("tmo next req", 32'(eng_req), 1);
    check("tmo next ch", 32'(eng_ch), 3);
    ack_after(0);
    check("tmo round_done", 32'(round_done), 1);
    check("tmo sticky hold", 32'(timeout_sticky), 32'h4);

    // Channel disable
    do_reset(16'd3, 4'b0111);
    wait_for("dis tick", 0, 10);
    clk_prescaler = 16'hFFFF;
    wait_for("dis req", 1, 10);
    check("dis first ch", 32'(eng_ch), 0);
    ch_enable = 4'b0101;
    step(1);
    check("dis pending", 32'(pending), 32'h5);
    check("dis still req", 32'(eng_req), 1);
    ack_after(0);
    check("dis pending gap", 32'(pending), 32'h4);
    wait_for("dis req2", 1, 10);
    check("dis skip ch1", 32'(eng_ch), 2);
    ack_after(0);
    check("dis round_done", 32'(round_done), 1);
    ch_enable     = 4'b0001;
    clk_prescaler = 16'd0;
    step(1);
    clk_prescaler = 16'hFFFF;
    check("dis lowered psc tick", 32'(tick), 1);
    wait_for("dis req3", 1, 10);
    check("dis ch0", 32'(eng_ch), 0);
    ch_enable = 4'b0000;
    step(1);
    check("dis ch0 pending", 32'(pending), 0);
    check("dis ch0 in flight", 32'(eng_req), 1);
    ack_after(0);
    check("dis ch0 done req", 32'(eng_req), 0);
    check("dis ch0 round_done", 32'(round_done), 1);
    check("dis ch0 no timeout", 32'(timeout_sticky), 0);

    // Asynchronous reset mid-issue
    do_reset(16'd0, 4'b1111);
    wait_for("rst req", 1, 10);
    check("rst pre overrun", 32'(overrun_sticky), 32'hF);
    check("rst pre busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst async req", 32'(eng_req), 0);
    check("rst async pending", 32'(pending), 0);
    check("rst async busy", 32'(busy), 0);
    check("rst async overrun", 32'(overrun_sticky), 0);
    check("rst async timeout", 32'(timeout_sticky), 0);
    clk_prescaler = 16'd3;
    step(1);
    rst_n = 1'b1;
    wait_for("rst post req", 1, 20);
    check("rst post ch", 32'(eng_ch), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
